prefetch_buffer: RTL and testbench

PREFETCH_BUFFER -- requirements
Module: prefetch_buffer

---
 rtl/mips_pkg.sv | 24 ++
 rtl/prefetch_fifo.sv | 64 ++++++
 rtl/prefetch_buffer.sv | 121 ++++++++++++
 tb/tb_prefetch_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared defaults, fetch FSM encoding and queue entry type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int          c_DEPTH    = 4;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_fifo
// Description : Circular instruction queue with flush; head is zero when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = c_DEPTH
)(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  fetch_entry_t           i_wdata,
    output fetch_entry_t           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == c_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage needs no reset: nothing reads it until the count says so.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_buffer
// Description : Instruction prefetch queue with single-outstanding memory fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module prefetch_buffer
    import mips_pkg::*;
#(
    parameter int          DEPTH    = c_DEPTH,
    parameter logic [31:0] RESET_PC = c_RESET_PC
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int          AW     = $clog2(DEPTH);
    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_next;
    logic [31:0]  r_mem_addr;
    logic [31:0]  w_mem_addr_next;
    logic [31:0]  w_addr_inc;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [AW:0]  w_count;
    logic [AW:0]  w_count_next;
    fetch_entry_t w_head;
    fetch_entry_t w_wdata;

    assign w_addr_inc   = r_mem_addr + 32'd4;
    assign w_push       = (r_state == ST_BUSY) && mem_ack && !redirect;
    assign w_pop        = !w_empty && !stall && !redirect;
    assign w_count_next = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_wdata      = '{pc: r_mem_addr, instr: mem_rdata};

    prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata (w_wdata),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_mem_addr <= w_mem_addr_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_mem_addr_next = r_mem_addr;
        unique case (r_state)
            ST_IDLE: begin
                // No push is possible here, so room means "not full or popping".
                if (redirect) begin
                    w_fetch_pc_next = redirect_pc;
                end else if (!w_full || w_pop) begin
                    w_state_next    = ST_BUSY;
                    w_mem_addr_next = r_fetch_pc;
                end
            end
            ST_BUSY: begin
                if (redirect) begin
                    w_fetch_pc_next = redirect_pc;
                    w_state_next    = mem_ack ? ST_IDLE : ST_DROP;
                end else if (mem_ack) begin
                    w_fetch_pc_next = w_addr_inc;
                    if (w_count_next < c_FULL) begin
                        w_mem_addr_next = w_addr_inc;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (redirect) w_fetch_pc_next = redirect_pc;
                if (mem_ack)  w_state_next    = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign mem_req     = (r_state != ST_IDLE);
    assign mem_addr    = r_mem_addr;
    assign instr_valid = !w_empty;
    assign instr       = w_head.instr;
    assign instr_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_buffer
// Description : Scoreboard bench; model is the sequential PC stream per redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_buffer;

    localparam int          c_DEPTH  = 4;
    localparam logic [31:0] c_RST_PC = 32'h0000_0000;
    localparam logic [31:0] c_KEY    = 32'hA5A5_A5A5;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];
    logic [31:0] m_pc = c_RST_PC;
    bit          m_stale = 1'b0;

    logic        p_valid = 1'b0;
    logic        p_req = 1'b0;
    logic [31:0] p_pc = '0;
    logic [31:0] p_ins = '0;
    logic [31:0] p_addr = '0;

    prefetch_buffer #(
        .DEPTH    (c_DEPTH),
        .RESET_PC (c_RST_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of inputs; the model follows the fetched PC stream.
    task automatic drive(input bit rd, input logic [31:0] rpc, input bit st, input bit ak);
        redirect    = rd;
        redirect_pc = rpc;
        stall       = st;
        mem_ack     = ak;
        mem_rdata   = ak ? (mem_addr ^ c_KEY) : $urandom;
        if (mem_req && ak) begin
            if (!rd && !m_stale) begin
                sb.push_back('{pc: m_pc, ins: m_pc ^ c_KEY});
                m_pc = m_pc + 32'd4;
            end
            m_stale = 1'b0;
        end else if (mem_req && rd) begin
            m_stale = 1'b1;
        end
        if (rd) begin
            sb.delete();
            m_pc = rpc;
        end
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        stall    = 1'b0;
        mem_ack  = 1'b0;
        sb.delete();
        m_pc    = c_RST_PC;
        m_stale = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: resolves what happened at the edge just passed.
    always @(negedge clk) begin
        if (!reset) begin
            if (p_valid && !stall && !redirect) begin
                if (sb.size() == 0) begin
                    chk("pop_unexpected", p_pc, 32'hDEAD_BEEF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pop_pc", p_pc, e.pc);
                    chk("pop_instr", p_ins, e.ins);
                end
            end
            chk("valid_vs_model", 32'(instr_valid), 32'(sb.size() != 0));
            if (p_req && !mem_ack) begin
                chk("req_held", 32'(mem_req), 32'd1);
                chk("addr_held", mem_addr, p_addr);
            end
        end
        p_valid = instr_valid;
        p_req   = mem_req;
        p_pc    = instr_pc;
        p_ins   = instr;
        p_addr  = mem_addr;
    end

    initial begin
        int n;
        bit rd;
        logic [31:0] rpc;

        do_reset();
        drive(0, 0, 0, 0);
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, c_RST_PC);
        for (int i = 0; i < 12; i++) begin
            drive(0, 0, 0, 1);
            chk("stream_valid", 32'(instr_valid), 32'd1);
            chk("stream_addr", mem_addr, c_RST_PC + 32'(4 * (i + 1)));
        end

        do_reset();
        for (int i = 0; i < 10; i++) drive(0, 0, 1, 1);
        chk("full_req", 32'(mem_req), 32'd0);
        chk("full_head_pc", instr_pc, c_RST_PC);
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (instr_valid) n++;
            drive(0, 0, 0, 0);
        end
        chk("full_count", 32'(n), 32'd4);

        do_reset();
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        chk("busy_at_8", mem_addr, 32'h8);
        drive(1, 32'h100, 0, 0);
        chk("drop_addr", mem_addr, 32'h8);
        chk("drop_req", 32'(mem_req), 32'd1);
        chk("drop_flush", 32'(instr_valid), 32'd0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("drop_addr_late", mem_addr, 32'h8);
        drive(0, 0, 0, 1);
        chk("drop_discard", 32'(instr_valid), 32'd0);
        chk("drop_idle", 32'(mem_req), 32'd0);
        drive(0, 0, 0, 0);
        chk("redir_addr", mem_addr, 32'h100);
        drive(0, 0, 0, 1);
        chk("redir_first_pc", instr_pc, 32'h100);
        chk("redir_first_ins", instr, 32'h100 ^ c_KEY);

        drive(1, 32'h200, 0, 1);
        chk("same_cyc_empty", 32'(instr_valid), 32'd0);
        chk("same_cyc_idle", 32'(mem_req), 32'd0);
        drive(0, 0, 0, 0);
        chk("same_cyc_addr", mem_addr, 32'h200);

        drive(1, 32'hFFFF_FFF8, 0, 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        chk("wrap_addr0", mem_addr, 32'hFFFF_FFF8);
        drive(0, 0, 0, 1);
        chk("wrap_addr1", mem_addr, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1);
        chk("wrap_addr2", mem_addr, 32'h0000_0000);
        drive(0, 0, 0, 1);

        drive(1, 32'h40, 1, 0);
        drive(0, 0, 1, 1);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1);
        drive(0, 0, 1, 0);
        chk("pre_rst_req", 32'(mem_req), 32'd1);
        chk("pre_rst_head", instr_pc, 32'h40);
        #2;
        reset = 1'b1;
        #1;
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_req", 32'(mem_req), 32'd0);
        chk("async_addr", mem_addr, 32'd0);
        chk("async_instr", instr, 32'd0);
        chk("async_pc", instr_pc, 32'd0);
        do_reset();
        drive(0, 0, 0, 1);
        chk("post_rst_ign", 32'(instr_valid), 32'd0);
        chk("post_rst_addr", mem_addr, c_RST_PC);
        chk("post_rst_req", 32'(mem_req), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ({$urandom} & 32'hC))
                                              : ({$urandom} & 32'hFFFF_FFFC);
            drive(rd, rpc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
        end
        drive(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
